// File: rtl/wb_pkg.sv
// wb_pkg: shared opcode patterns, FSM states and register constants for the writeback stage
package wb_pkg;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_MOVZ   = 11'b110100101??;
  localparam logic [10:0] OP_MOVN   = 11'b100100101??;
  localparam logic [10:0] OP_MOVK   = 11'b111100101??;
  localparam logic [4:0]  XZR       = 5'd31;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
endpackage

// File: rtl/wb_format.sv
// wb_format: combinational result formatter (load extension, MOVZ/MOVN/MOVK, ALU/PC select)
//   opcode/imm16/hw : decoded instruction fields
//   alu_result, incremented_pc, read_data2, mem_rdata : candidate operands
//   mem_to_reg : source select for non-special opcodes
//   result : formatted value (zero when illegal), illegal : bad MOV shift or mem_to_reg==3
module wb_format
  import wb_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [10:0]     opcode,
  input  logic [15:0]     imm16,
  input  logic [1:0]      hw,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] incremented_pc,
  input  logic [WORD-1:0] read_data2,
  input  logic [WORD-1:0] mem_rdata,
  input  logic [1:0]      mem_to_reg,
  output logic [WORD-1:0] result,
  output logic            illegal
);
  logic [5:0] sh;
  logic mov_ill;
  logic [WORD-1:0] imm_sh, raw;
  assign sh = {hw, 4'b0000};
  assign mov_ill = int'(sh) >= WORD;
  assign imm_sh = WORD'(imm16) << sh;
  always_comb begin
    raw = alu_result;
    illegal = 1'b0;
    casez (opcode)
      OP_LDUR:   raw = mem_rdata;
      OP_LDURB:  raw = WORD'(mem_rdata[7:0]);
      OP_LDURH:  raw = WORD'(mem_rdata[15:0]);
      OP_LDURSW: raw = WORD'($signed(mem_rdata[31:0]));
      OP_MOVZ:   begin raw = imm_sh; illegal = mov_ill; end
      OP_MOVN:   begin raw = ~imm_sh; illegal = mov_ill; end
      OP_MOVK:   begin raw = (read_data2 & ~(WORD'(16'hFFFF) << sh)) | imm_sh; illegal = mov_ill; end
      default: begin
        raw = mem_to_reg == 2'd1 ? mem_rdata : mem_to_reg == 2'd2 ? incremented_pc : alu_result;
        illegal = mem_to_reg == 2'd3;
      end
    endcase
  end
  assign result = illegal ? '0 : raw;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered, handshaked LEGv8 writeback stage with load-data wait and retire counter
//   in_valid/in_ready : accept handshake from memory stage
//   instruction, alu_result, incremented_pc, read_data2, mem_to_reg, reg_write : retiring instruction
//   mem_rdata_valid/mem_rdata : late load data
//   wb_en/wb_rd/wb_data : one-cycle register-file write, wb_err : illegal pulse, retire_count : commits
module wb_stage
  import wb_pkg::*;
#(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [WORD-1:0]      alu_result,
  input  logic [WORD-1:0]      incremented_pc,
  input  logic [WORD-1:0]      read_data2,
  input  logic [1:0]           mem_to_reg,
  input  logic                 reg_write,
  input  logic                 mem_rdata_valid,
  input  logic [WORD-1:0]      mem_rdata,
  output logic                 wb_en,
  output logic [4:0]           wb_rd,
  output logic [WORD-1:0]      wb_data,
  output logic                 wb_err,
  output logic [CNT_W-1:0]     retire_count
);
  state_t state, next;
  logic [INSTR_LEN-1:0] lat_ins, ins;
  logic [WORD-1:0] lat_rd2, rd2, result;
  logic lat_rw, rw, waiting, accept, go, illegal;
  logic [1:0] m2r;
  assign waiting = state == WAIT_MEM;
  assign in_ready = !waiting;
  assign accept = in_valid && in_ready;
  assign go = waiting ? mem_rdata_valid : accept && (mem_to_reg != 2'd1 || mem_rdata_valid);
  // While waiting on load data the formatter sees the latched instruction; only loads stall, so m2r is 1
  assign ins = waiting ? lat_ins : instruction;
  assign rd2 = waiting ? lat_rd2 : read_data2;
  assign rw = waiting ? lat_rw : reg_write;
  assign m2r = waiting ? 2'd1 : mem_to_reg;
  wb_format #(.WORD(WORD)) u_fmt (
    .opcode(ins[31:21]),
    .imm16(ins[20:5]),
    .hw(ins[22:21]),
    .alu_result(alu_result),
    .incremented_pc(incremented_pc),
    .read_data2(rd2),
    .mem_rdata(mem_rdata),
    .mem_to_reg(m2r),
    .result(result),
    .illegal(illegal)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = go ? COMMIT : (waiting || accept) ? WAIT_MEM : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lat_ins <= '0;
      lat_rd2 <= '0;
      lat_rw <= 1'b0;
      wb_en <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_err <= 1'b0;
      retire_count <= '0;
    end else begin
      if (accept) begin
        lat_ins <= instruction;
        lat_rd2 <= read_data2;
        lat_rw <= reg_write;
      end
      wb_en <= go && rw && ins[4:0] != XZR && !illegal;
      wb_err <= go && illegal;
      if (go) begin
        wb_rd <= ins[4:0];
        wb_data <= result;
        retire_count <= retire_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage at WORD=64 and WORD=32 against a behavioural model
module tb_wb_stage;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, reg_write, mem_rdata_valid;
  logic [31:0] instruction;
  logic [63:0] alu_result, incremented_pc, read_data2, mem_rdata;
  logic [1:0] mem_to_reg;
  logic rdy64, en64, err64, rdy32, en32, err32;
  logic [4:0] rd64, rd32;
  logic [63:0] data64;
  logic [31:0] data32;
  logic [15:0] cnt64, cnt32;
  int tests = 0;
  int fails = 0;
  logic waiting = 1'b0;
  logic [31:0] p_ins;
  logic [63:0] p_rd2;
  logic p_rw;
  logic [15:0] cnt = '0;
  always #5 clk = ~clk;
  wb_stage #(.WORD(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .instruction(instruction), .alu_result(alu_result), .incremented_pc(incremented_pc),
    .read_data2(read_data2), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .wb_en(en64), .wb_rd(rd64), .wb_data(data64), .wb_err(err64), .retire_count(cnt64)
  );
  wb_stage #(.WORD(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .instruction(instruction), .alu_result(alu_result[31:0]), .incremented_pc(incremented_pc[31:0]),
    .read_data2(read_data2[31:0]), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata[31:0]),
    .wb_en(en32), .wb_rd(rd32), .wb_data(data32), .wb_err(err32), .retire_count(cnt32)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input int w, input logic [31:0] ins, input logic [63:0] alu,
      input logic [63:0] pc, input logic [63:0] rd2, input logic [63:0] md, input logic [1:0] m2r,
      output logic ill);
    logic [10:0] op;
    int sh;
    logic [63:0] imm, r;
    op = ins[31:21];
    sh = int'(ins[22:21]) * 16;
    imm = 64'(ins[20:5]);
    ill = 1'b0;
    if (op == 11'h7C2) r = md;
    else if (op == 11'h1C2) r = md & 64'hFF;
    else if (op == 11'h3C2) r = md & 64'hFFFF;
    else if (op == 11'h5C4) r = {{32{md[31]}}, md[31:0]};
    else if (op[10:2] == 9'b110100101) begin r = imm << sh; ill = sh >= w; end
    else if (op[10:2] == 9'b100100101) begin r = ~(imm << sh); ill = sh >= w; end
    else if (op[10:2] == 9'b111100101) begin r = rd2; r[sh+:16] = ins[20:5]; ill = sh >= w; end
    else begin
      r = m2r == 2'd0 ? alu : m2r == 2'd1 ? md : m2r == 2'd2 ? pc : 64'd0;
      ill = m2r == 2'd3;
    end
    if (w == 32) r = r & 64'hFFFF_FFFF;
    return ill ? 64'd0 : r;
  endfunction
  // Applies the currently driven inputs for one clock and checks the registered result against the model
  task automatic cycle();
    logic commit, ill64, ill32, crw;
    logic [31:0] ci;
    logic [63:0] crd2, e64, e32;
    logic [1:0] cm;
    commit = 1'b0; ill64 = 1'b0; ill32 = 1'b0; crw = 1'b0; ci = '0; crd2 = '0; cm = '0; e64 = '0; e32 = '0;
    chk("in_ready64", rdy64, !waiting);
    chk("in_ready32", rdy32, !waiting);
    if (waiting) begin
      if (mem_rdata_valid) begin
        commit = 1'b1; ci = p_ins; crd2 = p_rd2; crw = p_rw; cm = 2'd1; waiting = 1'b0;
      end
    end else if (in_valid) begin
      ci = instruction; crd2 = read_data2; crw = reg_write; cm = mem_to_reg;
      if (mem_to_reg == 2'd1 && !mem_rdata_valid) begin
        waiting = 1'b1; p_ins = instruction; p_rd2 = read_data2; p_rw = reg_write;
      end else commit = 1'b1;
    end
    if (commit) begin
      e64 = model(64, ci, alu_result, incremented_pc, crd2, mem_rdata, cm, ill64);
      e32 = model(32, ci, alu_result, incremented_pc, crd2, mem_rdata, cm, ill32);
      cnt++;
    end
    @(posedge clk);
    #1;
    chk("wb_en64", en64, commit && crw && ci[4:0] != 5'd31 && !ill64);
    chk("wb_en32", en32, commit && crw && ci[4:0] != 5'd31 && !ill32);
    chk("wb_err64", err64, commit && ill64);
    chk("wb_err32", err32, commit && ill32);
    chk("count64", cnt64, cnt);
    chk("count32", cnt32, cnt);
    if (commit) begin
      chk("wb_data64", data64, e64);
      chk("wb_data32", 64'(data32), e32);
      chk("wb_rd64", rd64, ci[4:0]);
      chk("wb_rd32", rd32, ci[4:0]);
    end
  endtask
  initial begin
    logic [31:0] r;
    int k;
    reset = 1'b1; in_valid = 1'b0; reg_write = 1'b0; mem_rdata_valid = 1'b0; instruction = '0;
    alu_result = '0; incremented_pc = '0; read_data2 = '0; mem_rdata = '0; mem_to_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", {en64, en32}, 2'b00);
    chk("rst_err", {err64, err32}, 2'b00);
    chk("rst_rd", {rd64, rd32}, 10'd0);
    chk("rst_data", data64 | 64'(data32), 64'd0);
    chk("rst_cnt", {cnt64, cnt32}, 32'd0);
    chk("rst_ready", {rdy64, rdy32}, 2'b11);
    reset = 1'b0;
    // ADD x3
    instruction = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3};
    alu_result = 64'h1234; mem_to_reg = 2'd0; reg_write = 1'b1; in_valid = 1'b1;
    cycle();
    chk("add_data", data64, 64'h1234);
    chk("add_rd", rd64, 5'd3);
    chk("add_en", en64, 1'b1);
    chk("add_cnt", cnt64, 16'd1);
    // LDURSW with data three cycles after accept; in_valid held high must not be taken while waiting
    instruction = {11'h5C4, 9'd0, 2'b00, 5'd2, 5'd7}; mem_to_reg = 2'd1; mem_rdata_valid = 1'b0;
    cycle();
    instruction = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd9}; mem_to_reg = 2'd0;
    cycle();
    cycle();
    mem_rdata = 64'h0000_0000_8000_0001; mem_rdata_valid = 1'b1;
    cycle();
    chk("ldursw64", data64, 64'hFFFF_FFFF_8000_0001);
    chk("ldursw32", 64'(data32), 64'h8000_0001);
    chk("ldursw_rd", rd64, 5'd7);
    // LDURB with data in the accept cycle
    instruction = {11'h1C2, 9'd0, 2'b00, 5'd2, 5'd4}; mem_to_reg = 2'd1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFA5; mem_rdata_valid = 1'b1;
    cycle();
    chk("ldurb", data64, 64'hA5);
    // MOVZ then MOVK back-to-back
    mem_rdata_valid = 1'b0; mem_to_reg = 2'd0;
    instruction = {9'b110100101, 2'd3, 16'hBEEF, 5'd5};
    cycle();
    chk("movz", data64, 64'hBEEF_0000_0000_0000);
    chk("movz32_err", err32, 1'b1);
    instruction = {9'b111100101, 2'd0, 16'h1111, 5'd5}; read_data2 = 64'hBEEF_0000_0000_0000;
    cycle();
    chk("movk", data64, 64'hBEEF_0000_0000_1111);
    chk("movk_en", en64, 1'b1);
    // MOVN hw=2: illegal at WORD=32, legal at 64
    instruction = {9'b100100101, 2'd2, 16'h1234, 5'd6};
    cycle();
    chk("movn32_err", err32, 1'b1);
    chk("movn32_en", en32, 1'b0);
    chk("movn64", data64, 64'hFFFF_EDCB_FFFF_FFFF);
    instruction = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31};
    cycle();
    chk("xzr_en", en64, 1'b0);
    in_valid = 1'b0;
    cycle();
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 7);
      instruction = $urandom();
      r = $urandom();
      case (k)
        0: instruction[31:21] = 11'h7C2;
        1: instruction[31:21] = 11'h1C2;
        2: instruction[31:21] = 11'h3C2;
        3: instruction[31:21] = 11'h5C4;
        4: instruction[31:23] = 9'b110100101;
        5: instruction[31:23] = 9'b100100101;
        6: instruction[31:23] = 9'b111100101;
        default: instruction[31:21] = r[10:0];
      endcase
      in_valid = $urandom_range(0, 3) != 0;
      mem_to_reg = k < 4 ? 2'd1 : 2'($urandom_range(0, 3));
      reg_write = $urandom_range(0, 4) != 0;
      mem_rdata_valid = $urandom_range(0, 2) == 0;
      alu_result = {$urandom(), $urandom()};
      incremented_pc = {$urandom(), $urandom()};
      read_data2 = {$urandom(), $urandom()};
      mem_rdata = {$urandom(), $urandom()};
      cycle();
    end
    // Reset while waiting on load data
    in_valid = 1'b1; mem_to_reg = 2'd1; mem_rdata_valid = 1'b0; reg_write = 1'b1;
    instruction = {11'h7C2, 9'd0, 2'b00, 5'd2, 5'd8};
    if (waiting) begin
      mem_rdata_valid = 1'b1;
      cycle();
      mem_rdata_valid = 1'b0;
    end
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("wait_ready", rdy64, 1'b0);
    reset = 1'b1;
    #1;
    waiting = 1'b0; cnt = '0;
    chk("arst_en", {en64, en32, err64, err32}, 4'b0000);
    chk("arst_data", data64 | 64'(data32), 64'd0);
    chk("arst_cnt", {cnt64, cnt32}, 32'd0);
    chk("arst_ready", {rdy64, rdy32}, 2'b11);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 64'h55;
    cycle();
    chk("arst_nowrite", {en64, en32}, 2'b00);
    chk("arst_cnt_after", cnt64, 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, handshaked writeback stage for the LEGv8 pipeline, parametrised in data width. It accepts one retiring instruction per cycle from the memory stage and waits for late load data over a valid/ready handshake. It formats the result: load size/sign extension, MOVZ/MOVN/MOVK, ALU, or link PC. It drives a one-cycle register-file write port, which also serves as the forwarding source.

## Interface

Parameters:
- WORD, 64, datapath width; multiple of 16, at least 32
- INSTR_LEN, 32, instruction width
- CNT_W, 16, width of the retire counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- instruction  in  INSTR_LEN  retiring instruction; [31:21] opcode, [4:0] Rd
- alu_result  in  WORD  execute result
- incremented_pc  in  WORD  PC+4 for BL
- read_data2  in  WORD  current Rd value, used by MOVK
- mem_to_reg  in  2  0 ALU, 1 memory, 2 PC; 3 is illegal
- reg_write  in  1  instruction writes Rd
- mem_rdata_valid  in  1  load data is present
- mem_rdata  in  WORD  raw load data, LSB-aligned
- wb_en  out  1  register-file write strobe
- wb_rd  out  5  destination register
- wb_data  out  WORD  write data
- wb_err  out  1  one-cycle pulse on an illegal encoding
- retire_count  out  CNT_W  instructions committed, wraps

## Operation

- States are IDLE, WAIT_MEM and COMMIT. Reset state is IDLE. Reset values: wb_en=0, wb_rd=0, wb_data=0, wb_err=0, retire_count=0.
- in_ready = (state != WAIT_MEM). An instruction is accepted when in_valid && in_ready.
- On accept with mem_to_reg != 1, or with mem_to_reg == 1 and mem_rdata_valid high in the same cycle:
  - format the result, register it, go to COMMIT.
- On accept with mem_to_reg == 1 and mem_rdata_valid low:
  - latch instruction, read_data2 and reg_write, go to WAIT_MEM.
- WAIT_MEM: on mem_rdata_valid, format with the latched fields and go to COMMIT. Otherwise stay in WAIT_MEM.
- COMMIT:
  - wb_en = reg_write && Rd != 31 && !illegal.
  - retire_count increments by 1, including on XZR or illegal instructions.
  - A simultaneous accept follows the IDLE accept rules; with no accept, go to IDLE.
- mem_rdata_valid outside WAIT_MEM, and not coincident with a load accept, is ignored.
- Formatting is decided by opcode first; for any other opcode mem_to_reg selects the result:
  - LDUR: full mem_rdata
  - LDURB: zero-extend [7:0]
  - LDURH: zero-extend [15:0]
  - LDURSW: sign-extend [31:0]; for WORD=32 this is a pass-through
  - MOVZ: imm16 << hw*16, where imm16 = instruction[20:5] and hw = instruction[22:21]
  - MOVN: ~(imm16 << hw*16)
  - MOVK: read_data2 with bits [hw*16+:16] replaced by imm16
- Illegal encodings:
  - a MOV* with hw*16 >= WORD
  - mem_to_reg == 3 on a non-special opcode
  - Response: wb_data=0, wb_en=0, wb_err=1 in the COMMIT cycle.
- An asynchronous reset during WAIT_MEM or COMMIT discards the instruction: no write, no count.

## Timing

- Non-load latency: accepted in cycle N, wb_en/wb_data valid in cycle N+1 for exactly one cycle.
- Load latency: data valid in cycle M (M ≥ accept cycle), write in cycle M+1.
- Throughput is one instruction per cycle with no bubbles, except while waiting on load data.
- wb_* are registered outputs. in_ready is combinational from state only.
- The wb_* outputs are stable for exactly one cycle; the register file samples them at the following edge.

## Structure

- Package wb_pkg holds:
  - opcode constants as 11-bit casez patterns: LDUR 11111000010, LDURB 00111000010, LDURH 01111000010, LDURSW 10111000100, MOVZ 110100101??, MOVN 100100101??, MOVK 111100101??
  - the state enum
  - XZR = 31
- Sub-module wb_format, parametrised on WORD, is purely combinational. It maps the opcode, operands and raw data to a result plus an illegal flag. wb_stage instantiates it once and muxes live versus latched fields into it.

## Test plan

- ADD retires in cycle N with alu_result=0x1234, Rd=3 -> wb_en=1, wb_rd=3, wb_data=0x1234 in cycle N+1; retire_count=1.
- LDURSW with mem_rdata=0x00000000_80000001 arriving 3 cycles after accept:
  - in_ready=0 for those cycles
  - write of 0xFFFFFFFF_80000001 in the cycle after data arrives.
- LDURB with mem_rdata=0xFFFF_FFFF_FFFF_FFA5 in the accept cycle -> wb_data=0xA5 one cycle later, with no stall.
- MOVZ imm=0xBEEF, hw=3, then MOVK imm=0x1111, hw=0, read_data2=0xBEEF000000000000, back-to-back:
  - writes 0xBEEF000000000000, then 0xBEEF000000001111
  - in consecutive cycles, with in_ready constantly high.
- WORD=32, MOVN hw=2 -> wb_err pulse, wb_en=0, retire_count still increments; a write to Rd=31 also produces wb_en=0.
- reset asserted mid-WAIT_MEM -> outputs zero immediately; a later mem_rdata_valid produces no write; retire_count=0.
